// File: rtl/adder_accumulator.sv
// rtl/adder_accumulator.sv - valid/ready reduction stage folding operands through an adder
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  // Plain wrapping add; the carry-out is recovered downstream by comparison
  assign sum = a + b;

endmodule

module adder_accumulator #(
  parameter int WIDTH   = 32,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic [LEN_W-1:0] out_carries,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] CARRY_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] new_sum;
  logic [LEN_W-1:0] carries;
  logic [LEN_W-1:0] beats;
  logic [LEN_W-1:0] beats_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_clamped;
  logic             beat;
  logic             carry;

  adder #(.WIDTH(WIDTH)) u_adder (
    .a   (acc),
    .b   (in_data),
    .sum (new_sum)
  );

  assign beat        = (state == ACCUM) && in_valid;
  assign carry       = (new_sum < acc);
  assign beats_nxt   = beats + 1'b1;
  assign len_clamped = (len > MAX_LEN_L) ? MAX_LEN_L : len;

  // Next-state decode; a zero-length request goes straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (beat && (beats_nxt == len_q)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Accumulator and counters: cleared on an accepted start, advanced on each beat, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      carries <= '0;
      beats   <= '0;
      len_q   <= '0;
    end else if ((state == IDLE) && start) begin
      acc     <= '0;
      carries <= '0;
      beats   <= '0;
      len_q   <= len_clamped;
    end else if (beat) begin
      acc   <= new_sum;
      beats <= beats_nxt;
      if (carry && (carries != CARRY_MAX)) carries <= carries + 1'b1;
    end
  end

  // acc and carries are frozen outside ACCUM, so they double as the held result registers
  assign out_sum     = acc;
  assign out_carries = carries;
  assign in_ready    = (state == ACCUM);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_adder_accumulator.sv
// tb/tb_adder_accumulator.sv - directed self-checking bench for adder_accumulator
module tb_adder_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_sum;
  logic [4:0]  out_carries;
  logic        out_ready;
  logic        busy;

  int checks;
  int failures;
  int cyc;
  int t_start;

  adder_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .len         (len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_sum     (out_sum),
    .out_carries (out_carries),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation timeout");
  end

  task automatic start_red(input logic [4:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(posedge clk);
    #1;
    t_start = cyc;
    start   = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (!ok) @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL feed_handshake data=%h not accepted within 20 cycles", d);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = cyc - t_start + 1;
        break;
      end
    end
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b expected=000", {in_ready, out_valid, busy});
    end
    checks++;
    if (out_sum !== 32'h0) begin
      failures++;
      $display("FAIL reset_sum got=%h expected=00000000", out_sum);
    end
    checks++;
    if (out_carries !== 5'd0) begin
      failures++;
      $display("FAIL reset_carries got=%0d expected=0", out_carries);
    end
  endtask

  task automatic test_basic();
    int lat;
    start_red(5'd2);
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL basic_ready_after_start got=%b expected=11", {busy, in_ready});
    end
    feed(32'h8000001F);
    feed(32'h80000001);
    wait_valid(lat);
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL basic_latency got=%0d expected=3", lat);
    end
    checks++;
    if (out_sum !== 32'h00000020 || out_carries !== 5'd1) begin
      failures++;
      $display("FAIL basic_result got=%h/%0d expected=00000020/1", out_sum, out_carries);
    end
    accept();
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL basic_idle_after_accept got=%b expected=00", {busy, out_valid});
    end
  endtask

  task automatic test_wrap();
    int lat;
    start_red(5'd3);
    feed(32'hFFFFFFFF);
    feed(32'h00000001);
    feed(32'h00000001);
    wait_valid(lat);
    checks++;
    if (out_sum !== 32'h00000001 || out_carries !== 5'd1) begin
      failures++;
      $display("FAIL wrap3_result got=%h/%0d expected=00000001/1", out_sum, out_carries);
    end
    accept();
    start_red(5'd2);
    feed(32'h80000002);
    feed(32'h80000001);
    wait_valid(lat);
    checks++;
    if (out_sum !== 32'h00000003 || out_carries !== 5'd1) begin
      failures++;
      $display("FAIL wrap2_result got=%h/%0d expected=00000003/1", out_sum, out_carries);
    end
    accept();
  endtask

  task automatic test_len_zero();
    int lat;
    start_red(5'd0);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_in_ready got=%b expected=0", in_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL zero_latency got=%0d expected=1", lat);
    end
    checks++;
    if (out_sum !== 32'h0 || out_carries !== 5'd0) begin
      failures++;
      $display("FAIL zero_result got=%h/%0d expected=00000000/0", out_sum, out_carries);
    end
    accept();
  endtask

  task automatic test_clamp();
    int lat;
    start_red(5'd20);
    for (int i = 0; i < 16; i++) feed(32'h1);
    wait_valid(lat);
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL clamp_latency got=%0d expected=17", lat);
    end
    in_valid = 1'b1;
    in_data  = 32'h1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL clamp_extra_ready got=%b expected=0", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_sum !== 32'd16 || out_carries !== 5'd0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL clamp_result got=%h/%0d/v%b expected=00000010/0/v1", out_sum, out_carries, out_valid);
    end
    accept();
  endtask

  task automatic test_back_pressure();
    int lat;
    bit stable;
    start_red(5'd4);
    feed(32'h10);
    feed(32'h10);
    repeat (3) @(posedge clk);
    feed(32'h10);
    feed(32'h10);
    wait_valid(lat);
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL stall_latency got=%0d expected=8", lat);
    end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_sum !== 32'h40 || out_carries !== 5'd0) stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL hold_stable got=v%b/%h expected=v1/00000040 for 5 cycles", out_valid, out_sum);
    end
    accept();
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      failures++;
      $display("FAIL hold_idle_after_ready got=%b expected=00", {busy, out_valid});
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    start_red(5'd3);
    feed(32'd1);
    @(negedge clk);
    start = 1'b1;
    len   = 5'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    feed(32'd2);
    feed(32'd3);
    wait_valid(lat);
    checks++;
    if (lat !== 5 || out_sum !== 32'd6) begin
      failures++;
      $display("FAIL ignore_start got=lat%0d/%h expected=lat5/00000006", lat, out_sum);
    end
    accept();
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_queued got busy=%b expected=0", busy);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    start_red(5'd4);
    feed(32'h5);
    feed(32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset_flags got=%b expected=000", {busy, in_ready, out_valid});
    end
    checks++;
    if (out_sum !== 32'h0 || out_carries !== 5'd0) begin
      failures++;
      $display("FAIL async_reset_result got=%h/%0d expected=00000000/0", out_sum, out_carries);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_red(5'd1);
    feed(32'h7);
    wait_valid(lat);
    checks++;
    if (lat !== 2 || out_sum !== 32'h7 || out_carries !== 5'd0) begin
      failures++;
      $display("FAIL post_reset_run got=lat%0d/%h/%0d expected=lat2/00000007/0", lat, out_sum, out_carries);
    end
    accept();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    t_start   = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 5'd0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
    test_wrap();
    test_len_zero();
    test_clamp();
    test_back_pressure();
    test_start_ignored();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
